// File: rtl/fet_sel_pkg.sv
// Shared constants and FSM state type for the FET select sequencer.
package fet_sel_pkg;
    localparam int FET_N      = 32;
    localparam int FET_CODE_W = $clog2(FET_N);
    localparam int DWELL_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        DWELL
    } state_t;
endpackage

// File: rtl/fet_sel_seq_if.sv
// Control and code-stream signals between controller, sequencer and FET decoder.
interface fet_sel_seq_if
    import fet_sel_pkg::*;
;
    logic                  start;
    logic [FET_N-1:0]      mask;
    logic [DWELL_W-1:0]    dwell;
    logic [FET_CODE_W-1:0] code;
    logic                  code_valid;
    logic                  code_ready;
    logic                  busy;
    logic                  done;
    logic                  empty_err;

    // Sequencer side
    modport master (
        input  start, mask, dwell, code_ready,
        output code, code_valid, busy, done, empty_err
    );

    // Controller / downstream side
    modport slave (
        output start, mask, dwell, code_ready,
        input  code, code_valid, busy, done, empty_err
    );
endinterface

// File: rtl/fet_prio_enc.sv
// Lowest-set-bit priority encoder; o_any flags a non-zero input.
module fet_prio_enc #(
    parameter int FET_N  = 32,
    parameter int CODE_W = $clog2(FET_N)
) (
    input  logic [FET_N-1:0]  i_vec,
    output logic [CODE_W-1:0] o_code,
    output logic              o_any
);
    // Scan high to low so the lowest set bit is the last one written
    always_comb begin
        o_code = '0;
        o_any  = 1'b0;
        for (int i = FET_N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_code = CODE_W'(i);
                o_any  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fet_sel_seq.sv
// Sequential encoder: walks a FET enable mask lowest bit first, emitting one
// select code per handshake with an optional settle dwell between codes.
module fet_sel_seq
    import fet_sel_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    fet_sel_seq_if.master bus
);
    localparam logic [FET_N-1:0] ONE = FET_N'(1);

    state_t                r_state, w_state;
    logic [FET_N-1:0]      r_rem, w_rem;
    logic [FET_N-1:0]      w_rem_clr, w_enc_in;
    logic [FET_CODE_W-1:0] r_code, w_code, w_enc_code;
    logic [DWELL_W-1:0]    r_dwell, w_dwell, r_cnt, w_cnt;
    logic                  r_valid, w_valid, r_busy, w_busy;
    logic                  r_done, w_done, r_err, w_err;
    logic                  w_any;

    // Remaining bits with the code currently on the bus removed. In DWELL the
    // bit is already gone, so clearing it again is harmless.
    assign w_rem_clr = r_rem & ~(ONE << r_code);
    // In IDLE the first code comes straight from the incoming mask
    assign w_enc_in  = (r_state == IDLE) ? bus.mask : w_rem_clr;

    fet_prio_enc #(.FET_N(FET_N), .CODE_W(FET_CODE_W)) u_enc (
        .i_vec  (w_enc_in),
        .o_code (w_enc_code),
        .o_any  (w_any)
    );

    // Next-state and output decode; done/empty_err are single-cycle pulses
    always_comb begin
        w_state = r_state;
        w_rem   = r_rem;
        w_code  = r_code;
        w_dwell = r_dwell;
        w_cnt   = r_cnt;
        w_valid = r_valid;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (w_any) begin
                        w_rem   = bus.mask;
                        w_dwell = bus.dwell;
                        w_code  = w_enc_code;
                        w_valid = 1'b1;
                        w_busy  = 1'b1;
                        w_state = PRESENT;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            PRESENT: begin
                if (r_valid && bus.code_ready) begin
                    w_rem = w_rem_clr;
                    if (r_dwell != '0) begin
                        w_valid = 1'b0;
                        w_cnt   = r_dwell;
                        w_state = DWELL;
                    end else if (w_any) begin
                        w_code = w_enc_code;
                    end else begin
                        w_valid = 1'b0;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_state = IDLE;
                    end
                end
            end
            DWELL: begin
                w_cnt = r_cnt - 1'b1;
                if (r_cnt == DWELL_W'(1)) begin
                    if (w_any) begin
                        w_code  = w_enc_code;
                        w_valid = 1'b1;
                        w_state = PRESENT;
                    end else begin
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_state = IDLE;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    // State and output registers; reset aborts any scan in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_code  <= '0;
            r_dwell <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_rem   <= w_rem;
            r_code  <= w_code;
            r_dwell <= w_dwell;
            r_cnt   <= w_cnt;
            r_valid <= w_valid;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_err   <= w_err;
        end
    end

    assign bus.code       = r_code;
    assign bus.code_valid = r_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.empty_err  = r_err;
endmodule

// File: tb/tb_fet_sel_seq.sv
// Directed bench for fet_sel_seq with a code scoreboard on the handshake.
module tb_fet_sel_seq;
    import fet_sel_pkg::*;

    logic clk;
    logic rst_n;
    int   errs;
    int   checks;
    logic [FET_CODE_W-1:0] sb[$];
    logic                  prev_stall;
    logic [FET_CODE_W-1:0] prev_code;

    fet_sel_seq_if bus ();

    fet_sel_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected codes go into the scoreboard as the start is driven
    task automatic do_start(input logic [31:0] m, input logic [7:0] d);
        for (int i = 0; i < FET_N; i++)
            if (m[i]) sb.push_back(FET_CODE_W'(i));
        bus.start = 1'b1;
        bus.mask  = m;
        bus.dwell = d;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [4:0] c,
                           input logic b, input logic dn);
        chk({tag, "_valid"}, 32'(bus.code_valid), 32'(v));
        if (v) chk({tag, "_code"}, 32'(bus.code), 32'(c));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(b));
        chk({tag, "_done"}, 32'(bus.done), 32'(dn));
    endtask

    // Scoreboard pop on each handshake, plus hold-stability under back-pressure
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(bus.code_valid), 32'd1);
                chk("stall_code", 32'(bus.code), 32'(prev_code));
            end
            if (bus.code_valid && bus.code_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errs++;
                    $error("FAIL sb_extra obs=%0d exp=none", bus.code);
                end else begin
                    chk("sb_code", 32'(bus.code), 32'(sb.pop_front()));
                end
            end
            prev_stall = bus.code_valid && !bus.code_ready;
            prev_code  = bus.code;
        end
    end

    initial begin
        errs = 0;
        checks = 0;
        prev_stall = 1'b0;
        prev_code = '0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.mask = '0;
        bus.dwell = '0;
        bus.code_ready = 1'b1;
        tick();
        tick();
        chk_out("rst", 1'b0, 5'd0, 1'b0, 1'b0);
        chk("rst_code", 32'(bus.code), 32'd0);
        chk("rst_err", 32'(bus.empty_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // single bit, no dwell
        do_start(32'h0000_0001, 8'd0);
        chk_out("t1_c0", 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        chk_out("t1_done", 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        chk("t1_done_pulse", 32'(bus.done), 32'd0);
        chk("t1_sb", 32'(sb.size()), 32'd0);

        // streaming, one code per cycle
        do_start(32'h8000_0011, 8'd0);
        chk_out("t2_c0", 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        chk_out("t2_c4", 1'b1, 5'd4, 1'b1, 1'b0);
        tick();
        chk_out("t2_c31", 1'b1, 5'd31, 1'b1, 1'b0);
        tick();
        chk_out("t2_done", 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        chk("t2_sb", 32'(sb.size()), 32'd0);

        // dwell of 3 between codes and before done
        do_start(32'h0000_0300, 8'd3);
        chk_out("t3_c8", 1'b1, 5'd8, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk_out("t3_dw1", 1'b0, 5'd0, 1'b1, 1'b0);
            chk("t3_dw1_code", 32'(bus.code), 32'd8);
            tick();
        end
        chk_out("t3_c9", 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk_out("t3_dw2", 1'b0, 5'd0, 1'b1, 1'b0);
            tick();
        end
        chk_out("t3_done", 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        chk("t3_sb", 32'(sb.size()), 32'd0);

        // back-pressure, and a start while busy must be ignored
        bus.code_ready = 1'b0;
        do_start(32'h0000_0024, 8'd0);
        for (int k = 0; k < 10; k++) begin
            chk_out("t4_hold", 1'b1, 5'd2, 1'b1, 1'b0);
            bus.start = (k == 3);
            bus.mask  = (k >= 3) ? 32'hFFFF_FFFF : 32'h0000_0024;
            tick();
        end
        bus.start = 1'b0;
        bus.code_ready = 1'b1;
        chk_out("t4_c2", 1'b1, 5'd2, 1'b1, 1'b0);
        tick();
        chk_out("t4_c5", 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        chk_out("t4_done", 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        chk("t4_sb", 32'(sb.size()), 32'd0);

        // empty mask
        do_start(32'h0, 8'd0);
        chk("t5_err", 32'(bus.empty_err), 32'd1);
        chk_out("t5", 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("t5_err_pulse", 32'(bus.empty_err), 32'd0);
        chk_out("t5_after", 1'b0, 5'd0, 1'b0, 1'b0);

        // reset during DWELL aborts the scan
        do_start(32'hFFFF_FFFF, 8'd5);
        chk_out("t6_c0", 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        tick();
        chk_out("t6_dw", 1'b0, 5'd0, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_out("t6_rst", 1'b0, 5'd0, 1'b0, 1'b0);
        chk("t6_rst_code", 32'(bus.code), 32'd0);
        chk("t6_rst_err", 32'(bus.empty_err), 32'd0);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        do_start(32'h0000_0004, 8'd0);
        chk_out("t6_c2", 1'b1, 5'd2, 1'b1, 1'b0);
        tick();
        chk_out("t6_done", 1'b0, 5'd0, 1'b0, 1'b1);
        tick();
        tick();
        chk_out("t6_idle", 1'b0, 5'd0, 1'b0, 1'b0);
        chk("t6_sb", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/fet_sel_seq.md
# fet_sel_seq

Sequential encoder for the NNSENSE FET selector: accepts a 32-bit FET enable mask and emits, one at a time, the 5-bit binary select code of each set bit over a valid/ready handshake, with a programmable settle dwell between codes. It sits upstream of the 5-to-32 one-hot FET decoder and is the encoding end of that select path. The controller loads a mask, pulses start, and waits for done.

## Interface
- FET_N, 32, number of FET select lines (mask width)
- CODE_W, 5, select code width, equal to clog2(FET_N)
- DWELL_W, 8, width of the dwell counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request; sampled only in IDLE
- mask  in  FET_N  FET enable mask; bit i selects code i; captured on accepted start
- dwell  in  DWELL_W  settle cycles after each accepted code; captured on accepted start
- code  out  CODE_W  current select code
- code_valid  out  1  code is presented and awaiting acceptance
- code_ready  in  1  downstream accepts code when high with code_valid
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse, scan completed
- empty_err  out  1  one-cycle pulse, start accepted with mask == 0

## Operation
- States: IDLE, PRESENT, DWELL.
- Working registers: rem_mask (FET_N), dwell_r (DWELL_W), cnt (DWELL_W).
- IDLE, start=1, mask!=0: capture rem_mask=mask and dwell_r=dwell; set code to the lowest set bit index; set code_valid=1 and busy=1; go to PRESENT.
- IDLE, start=1, mask==0: pulse empty_err; busy stays 0; no code is issued.
- PRESENT, handshake (code_valid & code_ready): clear bit `code` in rem_mask.
  - dwell_r==0 with bits remaining: code takes the next lowest set bit; code_valid stays 1; state stays PRESENT.
  - dwell_r==0 with no bits remaining: code_valid=0, busy=0, done=1; go to IDLE.
  - dwell_r>0: code_valid=0; cnt=dwell_r; go to DWELL. code holds its value.
- DWELL: cnt decrements each cycle. At cnt==1:
  - bits remaining: code takes the next lowest set bit, code_valid=1, go to PRESENT.
  - otherwise: busy=0, done=1, go to IDLE.
- Codes are issued in ascending order. Each set bit is issued exactly once.
- start is ignored outside IDLE. mask and dwell changes after capture have no effect.
- code is stable while code_valid=1 and code_ready=0.
- Reset mid-operation aborts the scan at once. There is no resume.

## Timing
- Reset values: code=0, code_valid=0, busy=0, done=0, empty_err=0, state=IDLE, rem_mask=0.
- All outputs are registered.
- start accepted at edge N: code_valid=1 after edge N, so the first code is visible in cycle N+1.
- mask==0: empty_err is high for exactly the cycle after edge N.
- With dwell=0 and code_ready held high, codes stream one per cycle. K set bits take K cycles of code_valid. done is high in the cycle after the last handshake.
- With dwell=D>0: code_valid is low for exactly D cycles between successive codes. D cycles also separate the last handshake from the done cycle.
- Next-code lookup is combinational within the same cycle; no extra bubble is added.
- busy deasserts in the same cycle done asserts. A new start is accepted in that cycle.

## Structure
- Package fet_sel_pkg holds: FET_N, FET_CODE_W, the state enum (IDLE, PRESENT, DWELL), and the default dwell width.
- Sub-module fet_prio_enc: FET_N→CODE_W lowest-set-bit priority encoder with an `any` output. It is purely combinational and instantiated once on rem_mask with the current bit masked off.

## Test plan
- mask=0x0000_0001, dwell=0, code_ready=1, start at edge N → code=0 valid in cycle N+1 only; done in cycle N+2.
- mask=0x8000_0011, dwell=0, code_ready=1 → codes 0, 4, 31 on three consecutive cycles; done the next cycle; busy high for all three cycles.
- mask=0x0000_0300, dwell=3, code_ready=1 → code 8 valid for 1 cycle; valid low for 3 cycles with code=8; code 9 valid for 1 cycle; 3 low cycles; then done.
- mask=0x0000_0024, code_ready low for 10 cycles, then start pulsed with mask=0xFFFF_FFFF while busy → code=2 held stable for 10 cycles; second start ignored; only codes 2 and 5 issued.
- mask=0 start → empty_err pulse in cycle N+1; busy, code_valid and done remain 0.
- rst_n low during DWELL of a 0xFFFF_FFFF scan → all outputs 0 immediately; after release, a start with mask=0x4 issues only code 2 and then done.
